// File: rtl/digit_scan_mux.sv
// digit_scan_mux -- time-multiplexed scan of a 4-digit value onto one shared
// digit-code bus for a seven-segment code converter.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   load_valid/ready   handshake offering a new 4-digit value
//   load_data[15:0]    digit 3 in [15:12] ... digit 0 in [3:0]
//   A,B,C,D            registered digit code of the active digit (A = MSB)
//   digit_en_n[3:0]    registered active-low one-cold digit enables
//   frame_done         one-cycle pulse on the last cycle of each 4-digit scan
//
// Parameter SCAN_DIV (1..2^20): cycles each digit stays lit.
// Optional macro LEADING_ZERO_BLANK_EN: digits 3..1 output 4'hF while they and
// every higher digit are zero; digit 0 is never blanked.
module digit_scan_mux #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_data,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic [3:0]  digit_en_n,
  output logic        frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    idx, idx_nx;
  logic [15:0]   disp, disp_nx, shadow;
  logic          pending, pending_nx;
  logic          tick, boundary, hs;
  logic [3:0]    code, code_nx;
  logic          fd_nx;

  function automatic logic [3:0] digit_code(input logic [15:0] v, input logic [1:0] k);
    logic [3:0] d;
    d = v[{k, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    case (k)
      2'd3:    if (v[15:12] == '0) d = 4'hF;
      2'd2:    if (v[15:8]  == '0) d = 4'hF;
      2'd1:    if (v[15:4]  == '0) d = 4'hF;
      default: ;
    endcase
`endif
    return d;
  endfunction

  assign load_ready = ~pending;
  assign hs         = load_valid & ~pending;
  assign tick       = (cnt == LAST);
  assign boundary   = tick & (idx == 2'd3);

  always_comb begin
    cnt_nx     = tick ? '0 : cnt + CW'(1);
    idx_nx     = tick ? idx + 2'd1 : idx;
    disp_nx    = disp;
    pending_nx = pending;
    // Swap only at the frame boundary so a frame never mixes two values.
    // A handshake on the boundary cycle implies pending was 0, so its value
    // waits for the following boundary.
    if (boundary && pending) begin
      disp_nx    = shadow;
      pending_nx = 1'b0;
    end
    if (hs) pending_nx = 1'b1;
    // Outputs are registered from next-state values so they change on the
    // same edge as the index, and frame_done lines up with the boundary tick.
    code_nx = digit_code(disp_nx, idx_nx);
    fd_nx   = (cnt_nx == LAST) && (idx_nx == 2'd3);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      disp       <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      code       <= '0;
      digit_en_n <= 4'b1110;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      disp       <= disp_nx;
      pending    <= pending_nx;
      if (hs) shadow <= load_data;
      code       <= code_nx;
      digit_en_n <= ~(4'b0001 << idx_nx);
      frame_done <= fd_nx;
    end
  end

  assign {A, B, C, D} = code;

endmodule

// File: tb/tb_digit_scan_mux.sv
// Bench for digit_scan_mux with SCAN_DIV = 4: reset, table of load values,
// ignored second load, frame_done cadence, reset with a pending load, and a
// randomized run checked every cycle against a time-since-reset model.
module tb_digit_scan_mux;
  localparam int DIV = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [3:0] BL = 4'hF;
`else
  localparam logic [3:0] BL = 4'h0;
`endif

  logic clk = 0, rst, load_valid, load_ready, A, B, C, D, frame_done;
  logic [15:0] load_data;
  logic [3:0]  digit_en_n;

  digit_scan_mux #(.SCAN_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .A(A), .B(B), .C(C), .D(D),
    .digit_en_n(digit_en_n), .frame_done(frame_done));

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // Model: cycles since reset plus the displayed/shadow value and pending flag.
  int          t;
  logic [15:0] m_disp, m_shadow;
  bit          m_pend;

  function automatic logic [3:0] mdig(logic [15:0] v, int k);
    logic [3:0] d;
    d = 4'((v >> (4 * k)) & 16'hF);
`ifdef LEADING_ZERO_BLANK_EN
    if (k > 0 && (v >> (4 * k)) == 16'h0) d = 4'hF;
`endif
    return d;
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
    end
  endtask

  // One clock: model absorbs the inputs seen at the edge, then all outputs
  // are compared 1 time unit later.
  task automatic step();
    bit boundary, hs;
    @(posedge clk);
    if (rst) begin
      t = 0; m_disp = 0; m_shadow = 0; m_pend = 0;
    end else begin
      boundary = (t % (4 * DIV)) == (4 * DIV - 1);
      hs = load_valid && !m_pend;
      if (boundary && m_pend) begin m_disp = m_shadow; m_pend = 0; end
      if (hs) begin m_shadow = load_data; m_pend = 1; end
      t++;
    end
    #1;
    begin
      int idx;
      idx = (t / DIV) % 4;
      chk("en_n", digit_en_n, 4'(~(4'b0001 << idx)));
      chk("abcd", {A, B, C, D}, mdig(m_disp, idx));
      chk("frame_done", frame_done, ((t % (4 * DIV)) == (4 * DIV - 1)) ? 1 : 0);
      chk("load_ready", load_ready, m_pend ? 0 : 1);
    end
  endtask

  typedef struct {
    logic [15:0] val;
    logic [3:0]  d0, d1, d2, d3;
  } vec_t;
  vec_t vt[5];

  initial begin
    vt[0] = '{16'h1234, 4'h4, 4'h3, 4'h2, 4'h1};
    vt[1] = '{16'h0070, 4'h0, 4'h7, BL,   BL};
    vt[2] = '{16'hABCD, 4'hD, 4'hC, 4'hB, 4'hA};
    vt[3] = '{16'h0005, 4'h5, BL,   BL,   BL};
    vt[4] = '{16'h0000, 4'h0, BL,   BL,   BL};

    t = 0; m_disp = 0; m_shadow = 0; m_pend = 0;
    rst = 1; load_valid = 0; load_data = 0;
    step(); step();
    rst = 0;
    chk("rst_en_n", digit_en_n, 4'b1110);
    chk("rst_abcd", {A, B, C, D}, 4'b0000);
    chk("rst_ready", load_ready, 1);
    chk("rst_fd", frame_done, 0);

    // Table: load, offer an ignored second value, then check a full frame.
    for (int r = 0; r < 5; r++) begin
      int n;
      logic [3:0] exp_d[4];
      exp_d[0] = vt[r].d0; exp_d[1] = vt[r].d1;
      exp_d[2] = vt[r].d2; exp_d[3] = vt[r].d3;
      n = 0;
      while (!load_ready && n < 40) begin step(); n++; end
      chk("ready_before_load", load_ready, 1);
      load_valid = 1; load_data = vt[r].val; step();
      chk("ready_while_pending", load_ready, 0);
      load_data = ~vt[r].val; step();
      load_valid = 0; load_data = 0;
      n = 0;
      while (!frame_done && n < 40) begin step(); n++; end
      chk("boundary_seen", frame_done, 1);
      for (int c = 0; c < 16; c++) begin
        step();
        chk("tbl_en_n", digit_en_n, 4'(~(4'b0001 << (c / DIV))));
        chk("tbl_abcd", {A, B, C, D}, exp_d[c / DIV]);
      end
    end

    // frame_done cadence over 64 free-running cycles.
    begin
      int pulses, last, gap_bad;
      pulses = 0; last = -1; gap_bad = 0;
      for (int c = 0; c < 64; c++) begin
        step();
        if (frame_done) begin
          if (last >= 0 && c - last != 16) gap_bad++;
          last = c; pulses++;
        end
      end
      chk("fd_pulses", pulses, 4);
      chk("fd_gap", gap_bad, 0);
    end

    // Reset at index 2 with a load pending: the value must never appear.
    begin
      int n, seen9;
      n = 0;
      while (!frame_done && n < 40) begin step(); n++; end
      step();
      load_valid = 1; load_data = 16'h9999; step(); load_valid = 0; load_data = 0;
      n = 0;
      while (digit_en_n != 4'b1011 && n < 40) begin step(); n++; end
      chk("at_index2", digit_en_n, 4'b1011);
      chk("pending_at_rst", load_ready, 0);
      rst = 1; step(); rst = 0;
      chk("mid_rst_en_n", digit_en_n, 4'b1110);
      chk("mid_rst_abcd", {A, B, C, D}, 4'b0000);
      chk("mid_rst_ready", load_ready, 1);
      seen9 = 0;
      for (int c = 0; c < 40; c++) begin
        step();
        if ({A, B, C, D} == 4'h9) seen9++;
      end
      chk("discarded_value", seen9, 0);
    end

    // Randomized loads with occasional resets, checked by the model each cycle.
    for (int c = 0; c < 600; c++) begin
      load_valid = ($urandom_range(0, 3) == 0);
      load_data  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) load_data[15:8] = 8'h00;
      rst = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 0; load_valid = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/digit_scan_mux.md
DIGIT_SCAN_MUX -- requirements
Module: digit_scan_mux

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, giving the clock cycles each digit is displayed; legal range 1 to 2^20.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port load_valid, input, 1 bit: a new 4-digit value is offered.
REQ-005 SHALL have port load_ready, output, 1 bit: the block can accept a value.
REQ-006 SHALL have port load_data, input, 16 bits: four 4-bit digits; [15:12] is digit 3 (most significant) and [3:0] is digit 0.
REQ-007 SHALL have ports A, B, C, D, outputs, 1 bit each: the digit code fed to the downstream seven-segment code converter; A is the MSB.
REQ-008 SHALL have port digit_en_n, output, 4 bits: active-low digit enables; bit k selects digit k.
REQ-009 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of each full 4-digit scan.

Function
REQ-010 SHALL run a prescaler counting 0..SCAN_DIV-1; the cycle with count = SCAN_DIV-1 is a tick, and the count wraps to 0 on that cycle.
REQ-011 SHALL keep a digit index 0..3 that advances by 1 on each tick and wraps from 3 to 0.
REQ-012 SHALL treat a tick with index 3 as the frame boundary, on which frame_done is 1 for exactly that cycle.
REQ-013 SHALL register all outputs: on the edge ending a tick, {A,B,C,D} and digit_en_n take the new index's digit and enable together.
REQ-014 SHALL drive digit_en_n with exactly one bit low (bit = index) at all times.
REQ-015 SHALL drive load_ready = NOT pending; the load handshake completes when load_valid and load_ready are both 1 in the same cycle.
REQ-016 SHALL, on handshake, capture load_data into a shadow register and set pending.
REQ-017 SHALL, at the frame boundary with pending = 1, copy the shadow register to the display register and clear pending; digit 0 output after that boundary comes from the new value (no mid-frame tearing).
REQ-018 SHALL, when a handshake and a frame boundary coincide, apply the captured value at the next frame boundary, not the current one.
REQ-019 SHALL ignore load_valid while load_ready = 0; the shadow register is unchanged.
REQ-020 SHALL pass digit codes 10-15 through unchanged; the downstream converter blanks them.
REQ-021 SHALL, with SCAN_DIV = 1, tick every cycle, advancing the index each cycle.

Reset
REQ-022 SHALL, in the cycle after rst = 1, have prescaler = 0, index = 0, display = 0, shadow = 0 and pending = 0.
REQ-023 SHALL, in that same cycle, drive {A,B,C,D} = 0000, digit_en_n = 1110, frame_done = 0 and load_ready = 1.
REQ-024 SHALL give rst priority over the handshake and over ticks; a reset mid-scan or with a load pending discards the pending value.

Configuration
REQ-025 SHALL support macro LEADING_ZERO_BLANK_EN; when defined, digit k (k = 3..1) outputs 1111 if digit k and all higher digits are zero, and digit 0 is never blanked.
REQ-026 SHALL, without LEADING_ZERO_BLANK_EN, output every digit code unmodified; in both builds digit_en_n scanning is identical.

Verification (SCAN_DIV = 4)
REQ-027 SHALL check reset: rst = 1 for 2 cycles, then low -> digit_en_n = 1110, ABCD = 0000, load_ready = 1, frame_done = 0.
REQ-028 SHALL check load 16'h1234 -> after the next frame boundary, ABCD sequence 0100, 0011, 0010, 0001 with enables 1110, 1101, 1011, 0111, each held 4 cycles.
REQ-029 SHALL check a second load_valid while pending, with load_ready = 0 -> it is ignored and only the first value is displayed.
REQ-030 SHALL check free run for 64 cycles -> frame_done pulses exactly once every 16 cycles, each pulse 1 cycle wide.
REQ-031 SHALL check load 16'h0070 -> digits 3 and 2 output 1111 with the macro, 0000 without it; digit 1 = 0111 and digit 0 = 0000 in both builds.
REQ-032 SHALL check rst asserted at index 2 with a load pending -> the next cycle shows index 0 and ABCD = 0000, and the pending value is never displayed.
